// File: rtl/orient_hist_pkg.sv
// Shared constants and FSM state encoding for the orientation histogram
// and the downstream descriptor block.
package orient_hist_pkg;

    localparam int NBINS   = 36;
    localparam int DEG_MAX = 360;
    localparam int BW      = DEG_MAX / NBINS;
    localparam int BIN_W   = 6;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SCAN  = 2'd2,
        ST_OUT   = 2'd3
    } oh_state_e;

endpackage

// File: rtl/deg_to_bin.sv
// Registered degree -> angular bin conversion with illegal-degree flag.
// Bin index is found by comparing against multiples of the bin width,
// which is exact for every legal degree without a divider.
module deg_to_bin #(
    parameter int NBINS = 36,
    parameter int DEG_W = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              vld_i,
    input  logic [DEG_W-1:0]                  deg_i,
    output logic                              vld_o,
    output logic [orient_hist_pkg::BIN_W-1:0] bin_o,
    output logic                              bad_o
);
    import orient_hist_pkg::*;

    localparam int BW_P = DEG_MAX / NBINS;

    logic [BIN_W-1:0] bin_d, bin_q;
    logic             bad_d;
    logic             vld_q, bad_q;

    // Bin = number of bin boundaries at or below the degree; flag out-of-range
    always_comb begin
        bin_d = '0;
        bad_d = (deg_i >= DEG_W'(DEG_MAX));
        for (int k = 1; k < NBINS; k++) begin
            if (deg_i >= DEG_W'(k * BW_P)) begin
                bin_d = BIN_W'(k);
            end
        end
    end

    // Stage 1 register: illegal samples are dropped but reported
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            vld_q <= vld_i & ~bad_d;
            bad_q <= vld_i & bad_d;
        end
        bin_q <= bin_d;
    end

    assign vld_o = vld_q;
    assign bad_o = bad_q;
    assign bin_o = bin_q;

endmodule

// File: rtl/orient_hist.sv
// Orientation histogram: accumulates magnitude-weighted votes per angular
// bin over one keypoint window, then scans for the dominant bin and emits
// a single held result with a one-cycle valid pulse.
module orient_hist #(
    parameter int NBINS = orient_hist_pkg::NBINS,
    parameter int DEG_W = 12,
    parameter int MAG_W = 10,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEG_W-1:0] in_degree,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    output logic             out_valid,
    output logic [5:0]       out_bin,
    output logic [DEG_W-1:0] out_peak_deg,
    output logic [ACC_W-1:0] out_peak_val,
    output logic             out_sat,
    output logic             out_bad
);
    import orient_hist_pkg::*;

    localparam int BW_L  = DEG_MAX / NBINS;
    localparam int SUM_W = ACC_W + 1;

    oh_state_e        state_q, state_d;
    logic             accept;
    logic             vld_p1, bad_p1;
    logic [BIN_W-1:0] bin_p1;
    logic [MAG_W-1:0] mag_p1_q;
    logic [ACC_W-1:0] bins_q [NBINS];
    logic [ACC_W:0]   acc_res;
    logic             sat_q, bad_q;
    logic [BIN_W-1:0] scan_idx_q, max_idx_q, cand_idx;
    logic [ACC_W-1:0] max_val_q, cand_val;
    logic             scan_last;
    logic [DEG_W-1:0] peak_deg_d;
    logic [5:0]       out_bin_q;
    logic [DEG_W-1:0] out_deg_q;
    logic [ACC_W-1:0] out_val_q;
    logic             out_sat_q, out_bad_q;

    // Saturating add; MSB of the result is the saturation indicator
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + SUM_W'(b);
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return sum;
    endfunction

    assign accept    = in_valid & in_ready;
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);

    deg_to_bin #(.NBINS(NBINS), .DEG_W(DEG_W)) u_deg_to_bin (
        .clk   (clk),
        .rst   (rst),
        .vld_i (accept),
        .deg_i (in_degree),
        .vld_o (vld_p1),
        .bin_o (bin_p1),
        .bad_o (bad_p1)
    );

    // Stage 1: magnitude travels alongside the bin index
    always_ff @(posedge clk) begin
        if (accept) begin
            mag_p1_q <= in_mag;
        end
    end

    assign acc_res = sat_add(bins_q[bin_p1], mag_p1_q);

    // Stage 2: bin accumulation; bins clear on reset and after each result
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_OUT) begin
            for (int i = 0; i < NBINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (vld_p1) begin
            bins_q[bin_p1] <= acc_res[ACC_W-1:0];
        end
    end

    // Sticky per-window saturation and illegal-degree flags
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_OUT) begin
            sat_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            sat_q <= sat_q | (vld_p1 & acc_res[ACC_W]);
            bad_q <= bad_q | bad_p1;
        end
    end

    // Running maximum candidate; strict compare keeps the lowest index on ties
    always_comb begin
        cand_val = max_val_q;
        cand_idx = max_idx_q;
        if (bins_q[scan_idx_q] > max_val_q) begin
            cand_val = bins_q[scan_idx_q];
            cand_idx = scan_idx_q;
        end
    end

    assign scan_last  = (scan_idx_q == BIN_W'(NBINS - 1));
    assign peak_deg_d = DEG_W'(cand_idx) * DEG_W'(BW_L) + DEG_W'(BW_L / 2);

    // Scan pointer and running max, restarted while draining
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_DRAIN) begin
            scan_idx_q <= '0;
            max_idx_q  <= '0;
            max_val_q  <= '0;
        end else if (state_q == ST_SCAN) begin
            scan_idx_q <= scan_idx_q + 1'b1;
            max_idx_q  <= cand_idx;
            max_val_q  <= cand_val;
        end
    end

    // Result registers, loaded on the final scan step and held until the next
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bin_q <= '0;
            out_deg_q <= '0;
            out_val_q <= '0;
            out_sat_q <= 1'b0;
            out_bad_q <= 1'b0;
        end else if (state_q == ST_SCAN && scan_last) begin
            out_bin_q <= 6'(cand_idx);
            out_deg_q <= peak_deg_d;
            out_val_q <= cand_val;
            out_sat_q <= sat_q;
            out_bad_q <= bad_q;
        end
    end

    assign out_bin      = out_bin_q;
    assign out_peak_deg = out_deg_q;
    assign out_peak_val = out_val_q;
    assign out_sat      = out_sat_q;
    assign out_bad      = out_bad_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: ACCUM -> DRAIN -> SCAN (NBINS cycles) -> OUT -> ACCUM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_SCAN;
            ST_SCAN:  if (scan_last) state_d = ST_OUT;
            ST_OUT:   state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

endmodule

// File: tb/tb_orient_hist.sv
// Bench for orient_hist: directed scenarios plus randomized windows,
// checked against a plain-arithmetic histogram model.
module tb_orient_hist;

    localparam int NB    = 36;
    localparam int BWD   = 360 / NB;
    localparam int ACCW  = 18;
    localparam int ACMAX = (1 << ACCW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_degree;
    logic [9:0]  in_mag;
    logic        in_last;
    logic        out_valid;
    logic [5:0]  out_bin;
    logic [11:0] out_peak_deg;
    logic [17:0] out_peak_val;
    logic        out_sat;
    logic        out_bad;

    int total = 0;
    int n_bad = 0;

    int qdeg[$];
    int qmag[$];
    int exp_bin, exp_deg, exp_val;
    bit exp_sat, exp_bad;

    always #5 clk = ~clk;

    orient_hist #(.NBINS(NB), .DEG_W(12), .MAG_W(10), .ACC_W(ACCW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_degree    (in_degree),
        .in_mag       (in_mag),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_bin      (out_bin),
        .out_peak_deg (out_peak_deg),
        .out_peak_val (out_peak_val),
        .out_sat      (out_sat),
        .out_bad      (out_bad)
    );

    // Reference: build the histogram from the window's sample list
    task automatic model();
        int hist[NB];
        int best;
        for (int b = 0; b < NB; b++) hist[b] = 0;
        exp_sat = 0;
        exp_bad = 0;
        foreach (qdeg[i]) begin
            if (qdeg[i] >= 360) begin
                exp_bad = 1;
            end else begin
                hist[qdeg[i] / BWD] += qmag[i];
                if (hist[qdeg[i] / BWD] > ACMAX) begin
                    hist[qdeg[i] / BWD] = ACMAX;
                    exp_sat = 1;
                end
            end
        end
        best = 0;
        exp_bin = 0;
        for (int b = 0; b < NB; b++) begin
            if (hist[b] > best) begin
                best = hist[b];
                exp_bin = b;
            end
        end
        exp_val = best;
        exp_deg = exp_bin * BWD + BWD / 2;
    endtask

    task automatic run_window(input string name, input bit gaps, input bit junk);
        bit not_ready = 0;
        bit early = 0;
        int n;
        model();
        for (int i = 0; i < qdeg.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                in_valid = 0;
                repeat (g) begin @(posedge clk); #1; end
            end
            in_valid  = 1;
            in_degree = 12'(qdeg[i]);
            in_mag    = 10'(qmag[i]);
            in_last   = (i == qdeg.size() - 1);
            if (!in_ready) not_ready = 1;
            @(posedge clk); #1;
        end
        in_valid = 0;
        in_last  = 0;
        n = 1;
        while (!out_valid && n < 60) begin
            if (in_ready) early = 1;
            if (junk) begin
                in_valid  = 1;
                in_degree = 12'($urandom_range(0, 359));
                in_mag    = 10'($urandom_range(0, 1023));
                in_last   = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 0;
        in_last  = 0;
        total++; if (not_ready !== 1'b0) begin n_bad++; $display("FAIL %s ready_feed: in_ready low while feeding got=%0d want=0", name, not_ready); end
        total++; if (n !== NB + 2) begin n_bad++; $display("FAIL %s latency: got=%0d want=%0d", name, n, NB + 2); end
        total++; if (early !== 1'b0) begin n_bad++; $display("FAIL %s ready_busy: in_ready high before result got=%0d want=0", name, early); end
        total++; if (out_bin !== 6'(exp_bin)) begin n_bad++; $display("FAIL %s out_bin: got=%0d want=%0d", name, out_bin, exp_bin); end
        total++; if (out_peak_deg !== 12'(exp_deg)) begin n_bad++; $display("FAIL %s out_peak_deg: got=%0d want=%0d", name, out_peak_deg, exp_deg); end
        total++; if (out_peak_val !== 18'(exp_val)) begin n_bad++; $display("FAIL %s out_peak_val: got=%0d want=%0d", name, out_peak_val, exp_val); end
        total++; if (out_sat !== exp_sat) begin n_bad++; $display("FAIL %s out_sat: got=%0d want=%0d", name, out_sat, exp_sat); end
        total++; if (out_bad !== exp_bad) begin n_bad++; $display("FAIL %s out_bad: got=%0d want=%0d", name, out_bad, exp_bad); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_after: got=%0d want=1", name, in_ready); end
        total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s pulse_width: out_valid got=%0d want=0", name, out_valid); end
        total++; if (out_peak_val !== 18'(exp_val) || out_bin !== 6'(exp_bin)) begin n_bad++; $display("FAIL %s hold: val got=%0d want=%0d bin got=%0d want=%0d", name, out_peak_val, exp_val, out_bin, exp_bin); end
    endtask

    task automatic test_reset();
        bit seen = 0;
        rst = 1; in_valid = 0; in_last = 0; in_degree = '0; in_mag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        total++; if (seen !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got=%0d want=0", seen); end
        total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got=%0d want=1", in_ready); end
        total++; if ({out_bin, out_peak_deg, out_peak_val, out_sat, out_bad} !== '0) begin n_bad++; $display("FAIL reset outputs: bin=%0d deg=%0d val=%0d sat=%0d bad=%0d want all 0", out_bin, out_peak_deg, out_peak_val, out_sat, out_bad); end
    endtask

    task automatic test_single();
        qdeg = {45}; qmag = {100};
        run_window("single", 0, 0);
    endtask

    task automatic test_tie();
        qdeg = {10, 350}; qmag = {50, 50};
        run_window("tie", 0, 0);
        qdeg = {200}; qmag = {7};
        run_window("cleared", 0, 0);
    endtask

    task automatic test_back_to_back();
        qdeg = {123, 123, 123, 123}; qmag = {300, 300, 300, 300};
        run_window("same_bin", 0, 0);
    endtask

    task automatic test_saturation();
        qdeg = {}; qmag = {};
        for (int i = 0; i < 258; i++) begin
            qdeg.push_back(i % 10);
            qmag.push_back(1023);
        end
        run_window("saturate", 0, 0);
    endtask

    task automatic test_bad_and_ignore();
        qdeg = {360, 4095}; qmag = {500, 600};
        run_window("only_bad", 0, 1);
        qdeg = {77, 400}; qmag = {0, 9};
        run_window("zero_mag", 0, 1);
        qdeg = {359, 4000, 0}; qmag = {11, 1023, 3};
        run_window("mixed_bad", 0, 1);
    endtask

    task automatic test_reset_mid_scan();
        bit seen = 0;
        in_valid = 1; in_degree = 12'd300; in_mag = 10'd999; in_last = 1;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_scan in_ready: got=%0d want=1", in_ready); end
        total++; if ({out_bin, out_peak_deg, out_peak_val, out_sat, out_bad} !== '0) begin n_bad++; $display("FAIL rst_scan outputs: bin=%0d val=%0d want 0", out_bin, out_peak_val); end
        repeat (50) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        total++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_scan aborted_pulse: got=%0d want=0", seen); end
        qdeg = {90}; qmag = {5};
        run_window("after_abort", 0, 0);
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            int len;
            len = $urandom_range(1, 10);
            qdeg = {}; qmag = {};
            for (int i = 0; i < len; i++) begin
                qdeg.push_back($urandom_range(0, 399));
                qmag.push_back($urandom_range(0, 1023));
            end
            run_window($sformatf("random%0d", w), 1, w[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_saturation();
        test_bad_and_ignore();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end

endmodule

// File: doc/orient_hist.md
Name: orient_hist

Overview:
- Orientation histogram stage directly downstream of the atan block.
- Consumes per-pixel (degree, magnitude) pairs for one keypoint window and accumulates magnitude-weighted votes into NBINS angular bins.
- At end of window, scans for the dominant bin and emits one result: peak bin, its centre angle and its accumulated weight.
- The result feeds descriptor/match logic.

Parameters:
- NBINS, 36: number of angular bins; must divide 360.
- DEG_W, 12: degree input width; matches the atan output.
- MAG_W, 10: magnitude input width.
- ACC_W, 18: per-bin accumulator width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_degree  in  DEG_W  unsigned integer degrees, legal 0..359
- in_mag  in  MAG_W  unsigned vote weight
- in_last  in  1  sample is last of window (qualified by in_valid&in_ready)
- out_valid  out  1  one-cycle result pulse
- out_bin  out  6  peak bin index
- out_peak_deg  out  DEG_W  peak bin centre angle = out_bin*BW + BW/2, with BW = 360/NBINS
- out_peak_val  out  ACC_W  peak bin accumulated weight
- out_sat  out  1  some bin saturated this window; valid with out_valid
- out_bad  out  1  some sample had degree ≥360 this window; valid with out_valid

Behaviour:
- Reset:
  - Every output is 0 except in_ready=1.
  - All bins are 0, state is ACCUM, sticky flags are cleared.
  - Reset at any cycle, including mid-SCAN, aborts the window with no out_valid.
- Handshake: a sample is accepted when in_valid&in_ready. While in_ready=0, in_valid is ignored and no data is lost.
- Pipeline stage 1, registered:
  - Computes bin = floor(in_degree/BW).
  - in_degree ≥360 marks the sample invalid: it is dropped, and the sticky bad flag is set.
- Pipeline stage 2, accumulate:
  - bin += mag, saturating at 2^ACC_W-1; on saturation the sticky sat flag is set.
  - Bins are flops, so back-to-back samples to the same bin accumulate correctly with no stall.
- FSM states: ACCUM → DRAIN → SCAN → OUT → ACCUM.
- ACCUM:
  - in_ready=1.
  - Accepting a sample with in_last=1 at cycle t moves the FSM to DRAIN, and in_ready drops at t+1.
- DRAIN (cycle t+1): the last sample completes stage 2.
- SCAN (cycles t+2 .. t+1+NBINS):
  - Reads one bin per cycle, index 0 upward.
  - Keeps the running max using strict greater-than, so ties resolve to the lowest index.
- OUT (cycle t+2+NBINS):
  - out_valid=1 with registered results.
  - All bins and the sat/bad flags clear at the end of this cycle.
  - in_ready=1 from t+3+NBINS.
- Output hold: out_* data holds its value after the pulse until the next OUT. Only out_valid is a pulse.
- Empty or all-zero window: out_bin=0, out_peak_deg=BW/2, out_peak_val=0.
- Window containing only bad samples: as the empty case, plus out_bad=1.
- Latency: in_last accept to out_valid is exactly NBINS+2 cycles. Minimum window-to-window gap is NBINS+3 cycles.
- Arithmetic:
  - Bin index uses a constant-divisor implementation: multiply by reciprocal, or compare against BW multiples.
  - The result must be exact for all 0..359.

Decomposition:
- Shared package holds NBINS, BW=360/NBINS, DEG_MAX=360, and the FSM state enum shared with the downstream descriptor block.
- One sub-module, deg_to_bin: registered degree→bin conversion plus the illegal-degree flag. It is reused later by descriptor binning.

Test Plan:
- Reset, then idle 10 cycles → in_ready=1, out_valid never asserted, all outputs 0.
- Single sample deg=45, mag=100, last=1 accepted at t → out_valid at t+38 with out_bin=4, out_peak_deg=45, out_peak_val=100, sat=0, bad=0; in_ready high again at t+39.
- Tie: deg=10/mag=50, then deg=350/mag=50/last → out_bin=1, out_peak_deg=15, out_peak_val=50. Second window, deg=200/mag=7/last → out_bin=20, val=7, confirming bins cleared.
- Same-bin back-to-back: 4 consecutive cycles at deg=123/mag=300 → bin 12, val=1200, out_peak_deg=125.
- Saturation with ACC_W=10: three samples deg=0/mag=1023 → val=1023, out_sat=1. Also deg=360 and deg=4095 inputs → dropped, out_bad=1. in_valid during SCAN → ignored, in_ready=0.
- rst asserted mid-SCAN → no out_valid; next window deg=90/mag=5/last → out_bin=9, val=5, with no residue from the aborted window.
